// File: rtl/fwd_hazard_unit.sv
// Forwarding select and hazard stall generation for a 5-stage RISC-V pipeline.
// Tracks EX/MEM destinations internally; fwd selects are registered as the consumer enters EX.
module fwd_hazard_unit #(
    parameter int unsigned INST_LENGTH     = 32,
    parameter int unsigned REG_ADDR_LENGTH = 5,
    parameter int unsigned OPCODE_LENGTH   = 7,
    parameter bit          FWD_EN          = 1'b1,
    parameter bit          LOAD_FWD_MEM    = 1'b1,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INST_LENGTH-1:0] id_inst,
    input  logic                   id_valid,
    input  logic                   hold,
    input  logic                   flush,
    output logic                   stall,
    output logic [1:0]             fwd1,
    output logic [1:0]             fwd2,
    output logic                   ex_valid,
    output logic [CNT_WIDTH-1:0]   stall_cnt
);

    localparam int unsigned RD_LSB  = OPCODE_LENGTH;
    localparam int unsigned RS1_LSB = OPCODE_LENGTH + REG_ADDR_LENGTH + 3;
    localparam int unsigned RS2_LSB = RS1_LSB + REG_ADDR_LENGTH;
    localparam int unsigned TOP_LSB = RS2_LSB + REG_ADDR_LENGTH;

    localparam logic [OPCODE_LENGTH-1:0] OPC_LOAD   = OPCODE_LENGTH'(7'b0000011);
    localparam logic [OPCODE_LENGTH-1:0] OPC_STORE  = OPCODE_LENGTH'(7'b0100011);
    localparam logic [OPCODE_LENGTH-1:0] OPC_BRANCH = OPCODE_LENGTH'(7'b1100011);
    localparam logic [OPCODE_LENGTH-1:0] OPC_OP     = OPCODE_LENGTH'(7'b0110011);
    localparam logic [OPCODE_LENGTH-1:0] OPC_LUI    = OPCODE_LENGTH'(7'b0110111);
    localparam logic [OPCODE_LENGTH-1:0] OPC_AUIPC  = OPCODE_LENGTH'(7'b0010111);
    localparam logic [OPCODE_LENGTH-1:0] OPC_JAL    = OPCODE_LENGTH'(7'b1101111);

    localparam logic [1:0] SEL_RF      = 2'b00;
    localparam logic [1:0] SEL_MEM_ALU = 2'b01;
    localparam logic [1:0] SEL_MEM_LD  = 2'b10;
    localparam logic [1:0] SEL_WB      = 2'b11;

    // ID decode
    logic [OPCODE_LENGTH-1:0]   id_opcode;
    logic [REG_ADDR_LENGTH-1:0] id_rd;
    logic [REG_ADDR_LENGTH-1:0] id_rs1;
    logic [REG_ADDR_LENGTH-1:0] id_rs2;
    logic                       id_writes_rd;
    logic                       id_is_load;
    logic                       id_uses_rs1;
    logic                       id_uses_rs2;

    assign id_opcode = id_inst[OPCODE_LENGTH-1:0];
    assign id_rd     = id_inst[RD_LSB  +: REG_ADDR_LENGTH];
    assign id_rs1    = id_inst[RS1_LSB +: REG_ADDR_LENGTH];
    assign id_rs2    = id_inst[RS2_LSB +: REG_ADDR_LENGTH];

    assign id_writes_rd = (id_opcode != OPC_BRANCH) && (id_opcode != OPC_STORE) &&
                          (id_rd != '0);
    assign id_is_load   = (id_opcode == OPC_LOAD);
    assign id_uses_rs1  = (id_opcode != OPC_LUI) && (id_opcode != OPC_AUIPC) &&
                          (id_opcode != OPC_JAL);
    assign id_uses_rs2  = (id_opcode == OPC_OP) || (id_opcode == OPC_STORE) ||
                          (id_opcode == OPC_BRANCH);

    // funct3 and funct7/immediate bits play no part in hazard detection
    logic unused_inst_bits;
    assign unused_inst_bits = ^{id_inst[RS1_LSB-1:RD_LSB+REG_ADDR_LENGTH],
                                id_inst[INST_LENGTH-1:TOP_LSB]};

    // Tracker entries
    logic                       ex_v_q;
    logic [REG_ADDR_LENGTH-1:0] ex_rd_q;
    logic                       ex_wr_q;
    logic                       ex_ld_q;
    logic                       mem_v_q;
    logic [REG_ADDR_LENGTH-1:0] mem_rd_q;
    logic                       mem_wr_q;

    logic m_ex1, m_ex2, m_mem1, m_mem2;

    assign m_ex1  = ex_v_q  && ex_wr_q  && (ex_rd_q  == id_rs1) && id_uses_rs1;
    assign m_ex2  = ex_v_q  && ex_wr_q  && (ex_rd_q  == id_rs2) && id_uses_rs2;
    assign m_mem1 = mem_v_q && mem_wr_q && (mem_rd_q == id_rs1) && id_uses_rs1;
    assign m_mem2 = mem_v_q && mem_wr_q && (mem_rd_q == id_rs2) && id_uses_rs2;

    logic hazard;
    logic enter;

    always_comb begin
        hazard = 1'b0;
        if (!FWD_EN) begin
            hazard = m_ex1 || m_ex2 || m_mem1 || m_mem2;
        end else if (!LOAD_FWD_MEM) begin
            hazard = ex_ld_q && (m_ex1 || m_ex2);
        end
    end

    // flush outranks any hazard: the ID instruction is discarded, not delayed
    assign stall = id_valid && !flush && hazard;
    assign enter = id_valid && !flush && !hazard;

    // The EX producer will sit in MEM when the consumer reaches EX, hence the shift by one stage
    function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem,
                                           input logic ex_is_load);
        logic [1:0] sel;
        sel = SEL_RF;
        if (FWD_EN) begin
            if (m_ex) begin
                sel = ex_is_load ? SEL_MEM_LD : SEL_MEM_ALU;
            end else if (m_mem) begin
                sel = SEL_WB;
            end
        end
        return sel;
    endfunction

    logic [1:0] fwd1_d;
    logic [1:0] fwd2_d;

    always_comb begin
        fwd1_d = SEL_RF;
        fwd2_d = SEL_RF;
        if (enter) begin
            fwd1_d = fwd_sel(m_ex1, m_mem1, ex_ld_q);
            fwd2_d = fwd_sel(m_ex2, m_mem2, ex_ld_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v_q    <= 1'b0;
            ex_rd_q   <= '0;
            ex_wr_q   <= 1'b0;
            ex_ld_q   <= 1'b0;
            mem_v_q   <= 1'b0;
            mem_rd_q  <= '0;
            mem_wr_q  <= 1'b0;
            fwd1      <= SEL_RF;
            fwd2      <= SEL_RF;
            stall_cnt <= '0;
        end else if (!hold) begin
            mem_v_q  <= ex_v_q;
            mem_rd_q <= ex_rd_q;
            mem_wr_q <= ex_wr_q;
            ex_v_q   <= enter;
            ex_rd_q  <= id_rd;
            ex_wr_q  <= id_writes_rd;
            ex_ld_q  <= id_is_load;
            fwd1     <= fwd1_d;
            fwd2     <= fwd2_d;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign ex_valid = ex_v_q;

endmodule
